rtc_bus_signal_driver: RTL and testbench

//  Consumes the 4-bit timing phase (0..11) from the timing-control counter and drives the RTC

---
 rtl/rtc_bus_pkg.sv | 30 +++
 rtl/rtc_bus_phase_decode.sv | 58 +++++
 rtl/rtc_bus_signal_driver.sv | 150 +++++++++++++++
 tb/tb_rtc_bus_signal_driver.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_bus_pkg.sv
// rtl/rtc_bus_pkg.sv - phase constants, FSM states and bus control types for the RTC bus driver
package rtc_bus_pkg;

  localparam int PH_IDLE      = 0;
  localparam int PH_ALE       = 1;
  localparam int PH_ALE_CS    = 2;
  localparam int PH_ADDR_HOLD = 3;
  localparam int PH_TURN      = 4;
  localparam int PH_DATA      = 5;
  localparam int PH_STROBE    = 6;
  localparam int PH_HOLD      = 7;
  localparam int PH_END       = 11;

  typedef enum logic [1:0] {IDLE, ARMED, RUN} state_e;

  typedef enum logic [1:0] {AD_ZERO, AD_ADDR, AD_WDATA} ad_sel_e;

  typedef struct packed {
    logic    ale;
    logic    cs_n;
    logic    rd_n;
    logic    wr_n;
    logic    ad_oe;
    ad_sel_e ad_sel;
  } bus_ctl_t;

  localparam bus_ctl_t BUS_IDLE = '{ale: 1'b0, cs_n: 1'b1, rd_n: 1'b1, wr_n: 1'b1,
                                    ad_oe: 1'b0, ad_sel: AD_ZERO};

endpackage

// File: rtl/rtc_bus_phase_decode.sv
// rtl/rtc_bus_phase_decode.sv - combinational phase + direction to bus control levels
module rtc_bus_phase_decode
  import rtc_bus_pkg::*;
#(
  parameter int PHASE_W = 4
) (
  input  logic [PHASE_W-1:0] phase,
  input  logic               write,
  output bus_ctl_t           ctl
);

  always_comb begin
    ctl = BUS_IDLE;
    case (phase)
      PHASE_W'(PH_ALE): begin
        ctl.ale    = 1'b1;
        ctl.ad_oe  = 1'b1;
        ctl.ad_sel = AD_ADDR;
      end
      PHASE_W'(PH_ALE_CS): begin
        ctl.ale    = 1'b1;
        ctl.cs_n   = 1'b0;
        ctl.ad_oe  = 1'b1;
        ctl.ad_sel = AD_ADDR;
      end
      PHASE_W'(PH_ADDR_HOLD): begin
        ctl.cs_n   = 1'b0;
        ctl.ad_oe  = 1'b1;
        ctl.ad_sel = AD_ADDR;
      end
      PHASE_W'(PH_DATA): begin
        if (write) begin
          ctl.ad_oe  = 1'b1;
          ctl.ad_sel = AD_WDATA;
        end
      end
      PHASE_W'(PH_STROBE): begin
        ctl.cs_n = 1'b0;
        if (write) begin
          ctl.wr_n   = 1'b0;
          ctl.ad_oe  = 1'b1;
          ctl.ad_sel = AD_WDATA;
        end else begin
          ctl.rd_n = 1'b0;
        end
      end
      PHASE_W'(PH_HOLD): begin
        ctl.cs_n = 1'b0;
        if (write) begin
          ctl.ad_oe  = 1'b1;
          ctl.ad_sel = AD_WDATA;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rtc_bus_signal_driver.sv
// rtl/rtc_bus_signal_driver.sv - RTC multiplexed bus driver; BUS_WATCHDOG_EN adds an op watchdog
module rtc_bus_signal_driver
  import rtc_bus_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PHASE_W     = 4,
  parameter int WDOG_CYCLES = 1023
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic               op_valid,
  output logic               op_ready,
  input  logic               op_write,
  input  logic [DATA_W-1:0]  op_addr,
  input  logic [DATA_W-1:0]  op_wdata,
  input  logic [DATA_W-1:0]  ad_in,
  output logic [DATA_W-1:0]  ad_out,
  output logic               ad_oe,
  output logic               ale,
  output logic               cs_n,
  output logic               rd_n,
  output logic               wr_n,
  output logic [DATA_W-1:0]  rdata,
  output logic               done,
  output logic               abort
);

  state_e             state, state_nxt;
  logic [PHASE_W-1:0] phase_q;
  logic               write_q;
  logic [DATA_W-1:0]  addr_q, wdata_q;
  logic               accept, at_start, at_zero, at_end, capture, wdog_hit;
  logic               done_nxt, abort_nxt;
  bus_ctl_t           ctl, bus_nxt;
  logic [DATA_W-1:0]  ad_nxt;

  assign op_ready = (state == IDLE);
  assign accept   = op_valid && op_ready;
  assign at_zero  = (phase_in == PHASE_W'(PH_IDLE));
  assign at_start = (phase_q == PHASE_W'(PH_IDLE)) && (phase_in == PHASE_W'(PH_ALE));
  assign at_end   = (phase_q == PHASE_W'(PH_END));
  // Last cycle with RD_n low on the pads: the phase counter has just stepped 6 -> 7
  assign capture  = (state == RUN) && !write_q && (phase_q == PHASE_W'(PH_STROBE)) &&
                    (phase_in == PHASE_W'(PH_HOLD));

`ifdef BUS_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_cnt <= '0;
    end else if (accept) begin
      wdog_cnt <= '0;
    end else if (state != IDLE) begin
      wdog_cnt <= wdog_cnt + WDOG_W'(1);
    end
  end

  assign wdog_hit = (state != IDLE) && (wdog_cnt == WDOG_W'(WDOG_CYCLES - 1));
`else
  logic wdog_unused;
  assign wdog_unused = (WDOG_CYCLES != 0);
  assign wdog_hit    = 1'b0;
`endif

  rtc_bus_phase_decode #(.PHASE_W(PHASE_W)) u_decode (
    .phase (phase_in),
    .write (write_q),
    .ctl   (ctl)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      phase_q <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_nxt;
      phase_q <= phase_in;
      if (accept) begin
        write_q <= op_write;
        addr_q  <= op_addr;
        wdata_q <= op_wdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    abort_nxt = 1'b0;
    unique case (state)
      IDLE:  if (accept) state_nxt = ARMED;
      ARMED: if (at_start) state_nxt = RUN;
      RUN: begin
        if (at_zero) begin
          state_nxt = IDLE;
          done_nxt  = at_end;
          abort_nxt = !at_end;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (wdog_hit) begin
      state_nxt = IDLE;
      done_nxt  = 1'b0;
      abort_nxt = 1'b1;
    end
  end

  // Bus levels follow the state being entered so outputs trail phase_in by exactly one clock
  always_comb begin
    bus_nxt = BUS_IDLE;
    if (state_nxt == RUN) bus_nxt = ctl;
    case (bus_nxt.ad_sel)
      AD_ADDR:  ad_nxt = addr_q;
      AD_WDATA: ad_nxt = wdata_q;
      default:  ad_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ale    <= 1'b0;
      cs_n   <= 1'b1;
      rd_n   <= 1'b1;
      wr_n   <= 1'b1;
      ad_oe  <= 1'b0;
      ad_out <= '0;
      rdata  <= '0;
      done   <= 1'b0;
      abort  <= 1'b0;
    end else begin
      ale    <= bus_nxt.ale;
      cs_n   <= bus_nxt.cs_n;
      rd_n   <= bus_nxt.rd_n;
      wr_n   <= bus_nxt.wr_n;
      ad_oe  <= bus_nxt.ad_oe;
      ad_out <= ad_nxt;
      done   <= done_nxt;
      abort  <= abort_nxt;
      if (capture) rdata <= ad_in;
    end
  end

endmodule

// File: tb/tb_rtc_bus_signal_driver.sv
// tb/tb_rtc_bus_signal_driver.sv - bench for rtc_bus_signal_driver against a behavioural op model
module tb_rtc_bus_signal_driver;

  localparam int WDOG = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] phase_in;
  logic       op_valid, op_ready, op_write;
  logic [7:0] op_addr, op_wdata, ad_in, ad_out, rdata;
  logic       ad_oe, ale, cs_n, rd_n, wr_n, done, abort;

  int checks = 0;
  int errors = 0;

  rtc_bus_signal_driver #(.DATA_W(8), .PHASE_W(4), .WDOG_CYCLES(WDOG)) dut (
    .clk(clk), .reset(reset), .phase_in(phase_in), .op_valid(op_valid), .op_ready(op_ready),
    .op_write(op_write), .op_addr(op_addr), .op_wdata(op_wdata), .ad_in(ad_in),
    .ad_out(ad_out), .ad_oe(ad_oe), .ale(ale), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n),
    .rdata(rdata), .done(done), .abort(abort)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         mode;
    bit         w;
    logic [7:0] addr, wd, rdata, ad;
    bit         done, abort, ale, cs_n, rd_n, wr_n, oe;
    int         pq;
    int         cnt;
  } mst_t;

  mst_t m;

  function automatic mst_t mreset();
    mst_t n;
    n.mode = 0; n.w = 0; n.addr = 0; n.wd = 0; n.rdata = 0; n.ad = 0;
    n.done = 0; n.abort = 0; n.ale = 0; n.cs_n = 1; n.rd_n = 1; n.wr_n = 1; n.oe = 0;
    n.pq = 0; n.cnt = 0;
    return n;
  endfunction

  // mode: 0 waiting for an op, 1 op held until the next 0->1 phase step, 2 op on the bus
  function automatic mst_t step(mst_t s, int ph, bit v, bit w, logic [7:0] a, logic [7:0] d,
                                logic [7:0] din);
    mst_t n = s;
    bit tmo = 0;
    n.done = 0; n.abort = 0; n.pq = ph;
`ifdef BUS_WATCHDOG_EN
    tmo = (s.mode != 0) && (s.cnt == WDOG - 1);
    if (s.mode != 0) n.cnt = s.cnt + 1;
`endif
    if (s.mode == 0 && v) begin
      n.mode = 1; n.w = w; n.addr = a; n.wd = d; n.cnt = 0;
    end else if (s.mode == 1 && s.pq == 0 && ph == 1) begin
      n.mode = 2;
    end else if (s.mode == 2) begin
      if (ph == 0) begin
        n.mode = 0;
        if (s.pq == 11) n.done = 1; else n.abort = 1;
      end else if (!s.w && s.pq == 6 && ph == 7) begin
        n.rdata = din;
      end
    end
    if (tmo) begin n.mode = 0; n.done = 0; n.abort = 1; end
    n.ale = 0; n.cs_n = 1; n.rd_n = 1; n.wr_n = 1; n.oe = 0; n.ad = 0;
    if (n.mode == 2) begin
      n.ale  = ph inside {1, 2};
      n.cs_n = !(ph inside {2, 3, 6, 7});
      n.wr_n = !(n.w && ph == 6);
      n.rd_n = !(!n.w && ph == 6);
      if (ph inside {[1:3]}) begin n.oe = 1; n.ad = n.addr; end
      else if (n.w && ph inside {[5:7]}) begin n.oe = 1; n.ad = n.wd; end
    end
    return n;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m <= mreset();
    else m <= step(m, int'(phase_in), op_valid, op_write, op_addr, op_wdata, ad_in);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("ale", ale, m.ale);
    chk("cs_n", cs_n, m.cs_n);
    chk("rd_n", rd_n, m.rd_n);
    chk("wr_n", wr_n, m.wr_n);
    chk("ad_oe", ad_oe, m.oe);
    if (m.oe) chk("ad_out", ad_out, m.ad);
    chk("rdata", rdata, m.rdata);
    chk("done", done, m.done);
    chk("abort", abort, m.abort);
    chk("op_ready", op_ready, m.mode == 0);
    chk("strobe_excl", rd_n | wr_n, 1);
    chk("oe_vs_rd", !(ad_oe && !rd_n), 1);
    chk("done_abort_excl", !(done && abort), 1);
  end

  task automatic ph(input int p);
    @(negedge clk);
    phase_in = 4'(p);
    @(posedge clk);
    #1;
  endtask

  task automatic accept_op(input bit w, input logic [7:0] a, input logic [7:0] d, input int p);
    @(negedge clk);
    phase_in = 4'(p); op_valid = 1; op_write = w; op_addr = a; op_wdata = d;
    @(posedge clk);
    #1;
    op_valid = 0;
  endtask

  initial begin
    int first;
    int rph;
    reset = 0; phase_in = 0; op_valid = 0; op_write = 0; op_addr = 0; op_wdata = 0; ad_in = 0;
    repeat (2) @(negedge clk);
    chk("rst_ale", ale, 0); chk("rst_cs_n", cs_n, 1); chk("rst_rd_n", rd_n, 1);
    chk("rst_wr_n", wr_n, 1); chk("rst_oe", ad_oe, 0); chk("rst_ad", ad_out, 0);
    chk("rst_rdata", rdata, 0); chk("rst_done", done, 0); chk("rst_abort", abort, 0);
    chk("rst_ready", op_ready, 1);
    #2 reset = 1;

    // write 0x59 to 0x21 across a full phase cycle
    accept_op(1, 8'h21, 8'h59, 0);
    chk("t1_ready", op_ready, 0);
    for (int p = 1; p <= 11; p++) begin
      ph(p);
      if (p == 1 || p == 2) begin chk("t1_ale", ale, 1); chk("t1_addr", ad_out, 8'h21); end
      if (p == 6) begin chk("t1_wr_n", wr_n, 0); chk("t1_wdata", ad_out, 8'h59); end
    end
    ph(0); chk("t1_done", done, 1);
    ph(1); chk("t1_done_pulse", done, 0); chk("t1_no_ale", ale, 0);

    // read 0x22 with 0xA5 on the pads while RD_n is low
    accept_op(0, 8'h22, 8'h00, 0);
    for (int p = 1; p <= 11; p++) begin
      ad_in = (p == 7) ? 8'hA5 : 8'h00;
      ph(p);
      if (p >= 4) chk("t2_oe", ad_oe, 0);
      if (p == 6) chk("t2_rd_n", rd_n, 0);
    end
    chk("t2_rdata", rdata, 8'hA5);
    ph(0); chk("t2_done", done, 1);

    // op accepted at phase 5 waits for the next 0->1 step
    for (int p = 1; p <= 4; p++) ph(p);
    accept_op(1, 8'h3C, 8'hC3, 5);
    for (int p = 6; p <= 11; p++) begin
      ph(p); chk("t3_quiet_cs", cs_n, 1); chk("t3_quiet_oe", ad_oe, 0);
    end
    ph(0); chk("t3_quiet_ale", ale, 0);
    ph(1); chk("t3_ale", ale, 1); chk("t3_addr", ad_out, 8'h3C);
    for (int p = 2; p <= 11; p++) ph(p);
    ph(0); chk("t3_done", done, 1);

    // counter reset to 0 at phase 6 of a write
    accept_op(1, 8'h44, 8'hBB, 0);
    for (int p = 1; p <= 6; p++) ph(p);
    chk("t4_wr_low", wr_n, 0);
    ph(0);
    chk("t4_abort", abort, 1); chk("t4_wr_n", wr_n, 1); chk("t4_oe", ad_oe, 0);
    chk("t4_ready", op_ready, 1); chk("t4_no_done", done, 0);
    ph(1); chk("t4_abort_pulse", abort, 0);

    // reset asserted while RD_n is low
    accept_op(0, 8'h55, 8'h00, 0);
    for (int p = 1; p <= 6; p++) ph(p);
    chk("t5_rd_low", rd_n, 0);
    #2 reset = 0; phase_in = 0;
    #1;
    chk("t5_rd_n", rd_n, 1); chk("t5_cs_n", cs_n, 1); chk("t5_oe", ad_oe, 0);
    chk("t5_ad", ad_out, 0); chk("t5_rdata", rdata, 0); chk("t5_ready", op_ready, 1);
    @(negedge clk); #2 reset = 1;

    // phase stalled at 3 with an op pending
    accept_op(0, 8'h66, 8'h00, 3);
    first = 0;
    for (int i = 1; i <= 60; i++) begin
      ph(3);
      if (abort && first == 0) first = i;
    end
`ifdef BUS_WATCHDOG_EN
    chk("t6_wdog_cycle", first, WDOG);
    chk("t6_ready", op_ready, 1);
`else
    chk("t6_no_abort", first, 0);
    chk("t6_still_armed", op_ready, 0);
    ph(0);
    for (int p = 1; p <= 11; p++) ph(p);
    ph(0); chk("t6_done", done, 1);
`endif

    // randomized counter behaviour and op traffic, checked every cycle by the model
    rph = int'(phase_in);
    for (int c = 0; c < 3000; c++) begin
      int r;
      @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 88) rph = (rph + 1) % 12;
      else if (r < 93) rph = 0;
      else if (r < 97) rph = $urandom_range(0, 15);
      phase_in = 4'(rph);
      op_valid = ($urandom_range(0, 3) == 0);
      op_write = $urandom_range(0, 1) == 1;
      op_addr  = 8'($urandom);
      op_wdata = 8'($urandom);
      ad_in    = 8'($urandom);
    end
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
